// File: rtl/cart_pkg.sv
// Shared scheme codes, hotspot geometry and bank helpers for the cartridge
// bank-switch controller.
package cart_pkg;

  localparam logic [2:0] SCH_4K = 3'd0;
  localparam logic [2:0] SCH_F8 = 3'd1;
  localparam logic [2:0] SCH_F6 = 3'd2;
  localparam logic [2:0] SCH_F4 = 3'd3;
  localparam logic [2:0] SCH_2K = 3'd4;

  localparam logic [11:0] F8_BASE = 12'hFF8;
  localparam logic [11:0] F6_BASE = 12'hFF6;
  localparam logic [11:0] F4_BASE = 12'hFF4;

  localparam logic [3:0] F8_BANKS = 4'd2;
  localparam logic [3:0] F6_BANKS = 4'd4;
  localparam logic [3:0] F4_BANKS = 4'd8;

  typedef struct packed {
    logic       hit;
    logic [2:0] bank;
  } hs_dec_t;

  function automatic logic is_banked(input logic [2:0] scheme);
    return (scheme == SCH_F8) || (scheme == SCH_F6) || (scheme == SCH_F4);
  endfunction

  function automatic logic [11:0] hs_base(input logic [2:0] scheme);
    case (scheme)
      SCH_F8:  return F8_BASE;
      SCH_F6:  return F6_BASE;
      SCH_F4:  return F4_BASE;
      default: return 12'h000;
    endcase
  endfunction

  // Zero banks for non-switching schemes so no offset can ever hit.
  function automatic logic [3:0] hs_banks(input logic [2:0] scheme);
    case (scheme)
      SCH_F8:  return F8_BANKS;
      SCH_F6:  return F6_BANKS;
      SCH_F4:  return F4_BANKS;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] last_bank(input logic [2:0] scheme);
    case (scheme)
      SCH_F8:  return 3'd1;
      SCH_F6:  return 3'd3;
      SCH_F4:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cart_hotspot_dec.sv
// Combinational hotspot decoder: flags an access inside the active scheme's
// hotspot range and returns the bank index it selects.
module cart_hotspot_dec
  import cart_pkg::*;
(
  input  logic [2:0]  scheme_i,
  input  logic [12:0] addr_i,
  output hs_dec_t     dec_o
);

  logic [11:0] base;
  logic [3:0]  banks;
  logic [11:0] offset;

  always_comb begin
    base   = hs_base(scheme_i);
    banks  = hs_banks(scheme_i);
    // Addresses below base wrap to a large offset and fail the range test.
    offset = addr_i[11:0] - base;
    dec_o.hit  = addr_i[12] && (offset < {8'd0, banks});
    dec_o.bank = offset[2:0];
  end

endmodule

// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switch controller: tracks the bank register from CPU hotspot
// accesses, expands the ROM address and carves out the Superchip RAM window.
module cart_bank_ctrl
  import cart_pkg::*;
#(
  parameter int unsigned ROM_AW         = 15,
  parameter int unsigned DEFAULT_SCHEME = 0,
  parameter bit          DEFAULT_SC     = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_enable_i,
  input  logic [12:0]       cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic              cfg_wr_i,
  input  logic [7:0]        cfg_dat_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              rom_cs_o,
  output logic              sc_cs_o,
  output logic              sc_we_o,
  output logic [6:0]        sc_addr_o,
  output logic [2:0]        bank_o,
  output logic [2:0]        scheme_o,
  output logic              switch_o
);

  localparam logic [2:0]  DefScheme = 3'(DEFAULT_SCHEME);
  localparam int unsigned FullW     = (ROM_AW > 15) ? ROM_AW : 15;

  logic [2:0] scheme_q, scheme_d;
  logic       sc_en_q, sc_en_d;
  logic [2:0] bank_q, bank_d;
  logic       switch_q, switch_d;

  hs_dec_t    hs_dec;
  logic       sc_window;
  logic [FullW-1:0] rom_full;
  logic [3:0] unused_cfg;

  assign unused_cfg = cfg_dat_i[7:4];

  cart_hotspot_dec u_hotspot_dec (
    .scheme_i (scheme_q),
    .addr_i   (cpu_addr_i),
    .dec_o    (hs_dec)
  );

  // Config load takes priority over a coincident hotspot hit.
  always_comb begin
    scheme_d = scheme_q;
    sc_en_d  = sc_en_q;
    bank_d   = bank_q;
    if (cfg_wr_i) begin
      scheme_d = cfg_dat_i[2:0];
      sc_en_d  = cfg_dat_i[3];
      bank_d   = last_bank(cfg_dat_i[2:0]);
    end else if (cpu_enable_i && hs_dec.hit) begin
      bank_d = hs_dec.bank;
    end
    switch_d = (bank_d != bank_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scheme_q <= DefScheme;
      sc_en_q  <= DEFAULT_SC;
      bank_q   <= last_bank(DefScheme);
      switch_q <= 1'b0;
    end else begin
      scheme_q <= scheme_d;
      sc_en_q  <= sc_en_d;
      bank_q   <= bank_d;
      switch_q <= switch_d;
    end
  end

  always_comb begin
    rom_full = '0;
    case (scheme_q)
      SCH_2K: rom_full[10:0] = cpu_addr_i[10:0];
      SCH_F8, SCH_F6, SCH_F4: begin
        rom_full[11:0]  = cpu_addr_i[11:0];
        rom_full[14:12] = bank_q;
      end
      default: rom_full[11:0] = cpu_addr_i[11:0];
    endcase
  end

  // Superchip occupies the first 256 bytes of the window: low half write, high half read.
  always_comb begin
    sc_window = sc_en_q && is_banked(scheme_q) && cpu_addr_i[12] &&
                (cpu_addr_i[11:8] == 4'h0);
    sc_cs_o   = sc_window;
    sc_we_o   = sc_window && !cpu_addr_i[7] && cpu_we_i && cpu_enable_i;
    rom_cs_o  = cpu_addr_i[12] && !sc_window;
  end

  assign rom_addr_o = rom_full[ROM_AW-1:0];
  assign sc_addr_o  = cpu_addr_i[6:0];
  assign bank_o     = bank_q;
  assign scheme_o   = scheme_q;
  assign switch_o   = switch_q;

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Table-driven bench for cart_bank_ctrl: combinational outputs checked in-cycle,
// registered outputs checked after the edge from a scoreboard queue.
module tb_cart_bank_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_enable_i;
  logic [12:0] cpu_addr_i;
  logic        cpu_we_i;
  logic        cfg_wr_i;
  logic [7:0]  cfg_dat_i;
  logic [14:0] rom_addr_o;
  logic        rom_cs_o;
  logic        sc_cs_o;
  logic        sc_we_o;
  logic [6:0]  sc_addr_o;
  logic [2:0]  bank_o;
  logic [2:0]  scheme_o;
  logic        switch_o;

  always #5 clk_i = ~clk_i;

  cart_bank_ctrl #(
    .ROM_AW         (15),
    .DEFAULT_SCHEME (2),
    .DEFAULT_SC     (1'b0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_enable_i (cpu_enable_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_we_i     (cpu_we_i),
    .cfg_wr_i     (cfg_wr_i),
    .cfg_dat_i    (cfg_dat_i),
    .rom_addr_o   (rom_addr_o),
    .rom_cs_o     (rom_cs_o),
    .sc_cs_o      (sc_cs_o),
    .sc_we_o      (sc_we_o),
    .sc_addr_o    (sc_addr_o),
    .bank_o       (bank_o),
    .scheme_o     (scheme_o),
    .switch_o     (switch_o)
  );

  typedef struct {
    logic        cfg_wr;
    logic [7:0]  cfg_dat;
    logic        en;
    logic [12:0] addr;
    logic        we;
    logic [14:0] rom;
    logic        rom_cs;
    logic        sc_cs;
    logic        sc_we;
    logic [2:0]  bank;
    logic [2:0]  sch;
    logic        sw;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] bank;
    logic [2:0] sch;
    logic       sw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic cw, input logic [7:0] cd, input logic en,
                     input logic [12:0] a, input logic we, input logic [14:0] rom,
                     input logic rcs, input logic scs, input logic swe,
                     input logic [2:0] bank, input logic [2:0] sch, input logic sw);
    vec_t v;
    v.cfg_wr = cw;  v.cfg_dat = cd; v.en = en; v.addr = a; v.we = we;
    v.rom = rom;    v.rom_cs = rcs; v.sc_cs = scs; v.sc_we = swe;
    v.bank = bank;  v.sch = sch;    v.sw = sw;
    vecs.push_back(v);
  endtask

  task automatic check_regs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s%0d bank", tag, e.idx), 32'(bank_o), 32'(e.bank));
      chk($sformatf("%s%0d scheme", tag, e.idx), 32'(scheme_o), 32'(e.sch));
      chk($sformatf("%s%0d switch", tag, e.idx), 32'(switch_o), 32'(e.sw));
    end
  endtask

  task automatic drive(input logic cw, input logic [7:0] cd, input logic en,
                       input logic [12:0] a, input logic we);
    cfg_wr_i = cw; cfg_dat_i = cd; cpu_enable_i = en; cpu_addr_i = a; cpu_we_i = we;
  endtask

  initial begin
    exp_t e;
    rst_ni = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 13'h0000, 1'b0);

    //   cw  cdat   en  addr     we  rom      rcs  scs  swe  bank sch  sw
    add(0, 8'h00, 1, 13'h1000, 0, 15'h3000, 1, 0, 0, 3'd3, 3'd2, 0);
    add(1, 8'h01, 0, 13'h0000, 0, 15'h3000, 0, 0, 0, 3'd1, 3'd1, 1);
    add(0, 8'h00, 1, 13'h1FF8, 0, 15'h1FF8, 1, 0, 0, 3'd0, 3'd1, 1);
    add(0, 8'h00, 1, 13'h1123, 0, 15'h0123, 1, 0, 0, 3'd0, 3'd1, 0);
    add(0, 8'h00, 1, 13'h1FF8, 0, 15'h0FF8, 1, 0, 0, 3'd0, 3'd1, 0);
    add(0, 8'h00, 0, 13'h1FF9, 0, 15'h0FF9, 1, 0, 0, 3'd0, 3'd1, 0);
    add(0, 8'h00, 1, 13'h1FF9, 1, 15'h0FF9, 1, 0, 0, 3'd1, 3'd1, 1);
    add(1, 8'h03, 0, 13'h0000, 0, 15'h1000, 0, 0, 0, 3'd7, 3'd3, 1);
    add(0, 8'h00, 1, 13'h1FFB, 0, 15'h7FFB, 1, 0, 0, 3'd7, 3'd3, 0);
    add(0, 8'h00, 1, 13'h1FFB, 0, 15'h7FFB, 1, 0, 0, 3'd7, 3'd3, 0);
    add(0, 8'h00, 1, 13'h1FF4, 0, 15'h7FF4, 1, 0, 0, 3'd0, 3'd3, 1);
    add(0, 8'h00, 1, 13'h1FFC, 0, 15'h0FFC, 1, 0, 0, 3'd0, 3'd3, 0);
    add(0, 8'h00, 1, 13'h1FF6, 0, 15'h0FF6, 1, 0, 0, 3'd2, 3'd3, 1);
    add(1, 8'h0A, 0, 13'h1000, 0, 15'h2000, 1, 0, 0, 3'd3, 3'd2, 1);
    add(0, 8'h00, 1, 13'h1005, 1, 15'h3005, 0, 1, 1, 3'd3, 3'd2, 0);
    add(0, 8'h00, 1, 13'h1085, 0, 15'h3085, 0, 1, 0, 3'd3, 3'd2, 0);
    add(0, 8'h00, 1, 13'h1085, 1, 15'h3085, 0, 1, 0, 3'd3, 3'd2, 0);
    add(0, 8'h00, 0, 13'h1005, 1, 15'h3005, 0, 1, 0, 3'd3, 3'd2, 0);
    add(0, 8'h00, 1, 13'h1100, 0, 15'h3100, 1, 0, 0, 3'd3, 3'd2, 0);
    add(1, 8'h01, 1, 13'h1FF6, 0, 15'h3FF6, 1, 0, 0, 3'd1, 3'd1, 1);
    add(1, 8'h04, 0, 13'h0000, 0, 15'h1000, 0, 0, 0, 3'd0, 3'd4, 1);
    add(0, 8'h00, 1, 13'h1FFF, 0, 15'h07FF, 1, 0, 0, 3'd0, 3'd4, 0);
    add(0, 8'h00, 1, 13'h17FF, 0, 15'h07FF, 1, 0, 0, 3'd0, 3'd4, 0);
    add(0, 8'h00, 1, 13'h1FF8, 0, 15'h07F8, 1, 0, 0, 3'd0, 3'd4, 0);
    add(1, 8'hFD, 0, 13'h1000, 0, 15'h0000, 1, 0, 0, 3'd0, 3'd5, 0);
    add(0, 8'h00, 1, 13'h1005, 1, 15'h0005, 1, 0, 0, 3'd0, 3'd5, 0);
    add(0, 8'h00, 1, 13'h1FF8, 0, 15'h0FF8, 1, 0, 0, 3'd0, 3'd5, 0);
    add(1, 8'h02, 0, 13'h0000, 0, 15'h0000, 0, 0, 0, 3'd3, 3'd2, 1);
    add(0, 8'h00, 1, 13'h1FF7, 0, 15'h3FF7, 1, 0, 0, 3'd1, 3'd2, 1);

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset bank", 32'(bank_o), 32'd3);
    chk("reset scheme", 32'(scheme_o), 32'd2);
    chk("reset switch", 32'(switch_o), 32'd0);

    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].cfg_wr, vecs[i].cfg_dat, vecs[i].en, vecs[i].addr, vecs[i].we);
      #1;
      chk($sformatf("v%0d rom_addr", i), 32'(rom_addr_o), 32'(vecs[i].rom));
      chk($sformatf("v%0d rom_cs", i), 32'(rom_cs_o), 32'(vecs[i].rom_cs));
      chk($sformatf("v%0d sc_cs", i), 32'(sc_cs_o), 32'(vecs[i].sc_cs));
      chk($sformatf("v%0d sc_we", i), 32'(sc_we_o), 32'(vecs[i].sc_we));
      chk($sformatf("v%0d sc_addr", i), 32'(sc_addr_o), 32'(vecs[i].addr[6:0]));
      e.idx = i; e.bank = vecs[i].bank; e.sch = vecs[i].sch; e.sw = vecs[i].sw;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      check_regs("v");
    end

    // Switch pulse lasts a single cycle: idle access after the F6 switch above.
    @(negedge clk_i);
    drive(1'b0, 8'h00, 1'b0, 13'h0000, 1'b0);
    e.idx = 100; e.bank = 3'd1; e.sch = 3'd2; e.sw = 1'b0;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check_regs("seq");

    // Reset mid-operation discards a coincident config write.
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(1'b1, 8'h03, 1'b1, 13'h1FF4, 1'b0);
    e.idx = 101; e.bank = 3'd3; e.sch = 3'd2; e.sw = 1'b0;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check_regs("seq");

    // After reset, the default F6 hotspot path still works.
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 13'h1FF6, 1'b0);
    #1;
    chk("seq102 rom_addr", 32'(rom_addr_o), 32'h3FF6);
    e.idx = 102; e.bank = 3'd0; e.sch = 3'd2; e.sw = 1'b1;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check_regs("seq");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
